// File: rtl/input_capa_sar_ctrl.sv
// Successive-approximation controller that matches a programmable test capacitance
// against the input capacitance of each enabled channel by comparing propagation times.
module input_capa_sar_ctrl #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CODE_W    = 6,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned RELAX_CYC = 8,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              evt_in,
    input  logic              evt_ref,
    input  logic              evt_tst,
    output logic [CH_W-1:0]   ch_sel,
    output logic              stim,
    output logic [CODE_W-1:0] cap_code,
    output logic              busy,
    output logic              res_valid,
    output logic [CH_W-1:0]   res_ch,
    output logic [CODE_W-1:0] res_code,
    output logic [CNT_W-1:0]  res_tref,
    output logic              res_timeout,
    output logic              done
);

    localparam int unsigned BIT_W = $clog2(CODE_W);
    localparam int unsigned RLX_W = (RELAX_CYC > 1) ? $clog2(RELAX_CYC) : 1;

    localparam logic [3:0] StIdle    = 4'd0;
    localparam logic [3:0] StSelect  = 4'd1;
    localparam logic [3:0] StStim    = 4'd2;
    localparam logic [3:0] StWaitIn  = 4'd3;
    localparam logic [3:0] StMeasure = 4'd4;
    localparam logic [3:0] StDecide  = 4'd5;
    localparam logic [3:0] StRelax   = 4'd6;
    localparam logic [3:0] StReport  = 4'd7;
    localparam logic [3:0] StDone    = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [N_CH-1:0]   ch_en_q, ch_en_d;
    logic [N_CH-1:0]   meas_q, meas_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [CODE_W-1:0] cap_code_q, cap_code_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  t_ref_q, t_ref_d;
    logic [CNT_W-1:0]  t_tst_q, t_tst_d;
    logic              got_ref_q, got_ref_d;
    logic              got_tst_q, got_tst_d;
    logic              timeout_q, timeout_d;
    logic [RLX_W-1:0]  relax_q, relax_d;
    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [CODE_W-1:0] res_code_q, res_code_d;
    logic [CNT_W-1:0]  res_tref_q, res_tref_d;
    logic              res_timeout_q, res_timeout_d;
    logic              done_q, done_d;

    logic [N_CH-1:0]   pend;
    logic              found;
    logic [CH_W-1:0]   first_ch;
    logic              ref_seen, tst_seen;

    assign pend     = ch_en_q & ~meas_q;
    // An event counts as seen if latched earlier or arriving this cycle
    assign ref_seen = got_ref_q | evt_ref;
    assign tst_seen = got_tst_q | evt_tst;

    // Lowest-index enabled channel not yet measured
    always_comb begin
        found    = 1'b0;
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pend[i]) begin
                found    = 1'b1;
                first_ch = CH_W'(i);
            end
        end
    end

    // Next-state and datapath update for the sweep FSM
    always_comb begin
        state_d       = state_q;
        ch_en_d       = ch_en_q;
        meas_d        = meas_q;
        ch_sel_d      = ch_sel_q;
        cap_code_d    = cap_code_q;
        bit_d         = bit_q;
        cnt_d         = cnt_q;
        t_ref_d       = t_ref_q;
        t_tst_d       = t_tst_q;
        got_ref_d     = got_ref_q;
        got_tst_d     = got_tst_q;
        timeout_d     = timeout_q;
        relax_d       = relax_q;
        res_valid_d   = 1'b0;
        res_ch_d      = res_ch_q;
        res_code_d    = res_code_q;
        res_tref_d    = res_tref_q;
        res_timeout_d = res_timeout_q;
        done_d        = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    ch_en_d = ch_en;
                    meas_d  = '0;
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (found) begin
                    ch_sel_d               = first_ch;
                    cap_code_d             = '0;
                    cap_code_d[CODE_W-1]   = 1'b1;
                    bit_d                  = BIT_W'(CODE_W - 1);
                    state_d                = StStim;
                end else begin
                    state_d = StDone;
                end
            end
            StStim: begin
                cnt_d     = '0;
                got_ref_d = 1'b0;
                got_tst_d = 1'b0;
                timeout_d = 1'b0;
                state_d   = StWaitIn;
            end
            StWaitIn: begin
                if (evt_in) begin
                    cnt_d   = '0;
                    state_d = StMeasure;
                end else if (&cnt_q) begin
                    timeout_d = 1'b1;
                    state_d   = StReport;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMeasure: begin
                if (evt_ref && !got_ref_q) begin
                    t_ref_d   = cnt_q;
                    got_ref_d = 1'b1;
                end
                if (evt_tst && !got_tst_q) begin
                    t_tst_d   = cnt_q;
                    got_tst_d = 1'b1;
                end
                // Completing events win over a simultaneous counter saturation
                if (ref_seen && tst_seen) begin
                    state_d = StDecide;
                end else if (&cnt_q) begin
                    timeout_d = 1'b1;
                    state_d   = StReport;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDecide: begin
                if (t_tst_q > t_ref_q) begin
                    cap_code_d[bit_q] = 1'b0;
                end
                if (bit_q != '0) begin
                    cap_code_d[bit_q - BIT_W'(1)] = 1'b1;
                    bit_d                         = bit_q - BIT_W'(1);
                    relax_d                       = '0;
                    state_d                       = StRelax;
                end else begin
                    state_d = StReport;
                end
            end
            StRelax: begin
                if (relax_q == RLX_W'(RELAX_CYC - 1)) begin
                    state_d = StStim;
                end else begin
                    relax_d = relax_q + RLX_W'(1);
                end
            end
            StReport: begin
                res_valid_d      = 1'b1;
                res_ch_d         = ch_sel_q;
                res_code_d       = cap_code_q;
                res_tref_d       = t_ref_q;
                res_timeout_d    = timeout_q;
                meas_d[ch_sel_q] = 1'b1;
                state_d          = StSelect;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers, all cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            ch_en_q       <= '0;
            meas_q        <= '0;
            ch_sel_q      <= '0;
            cap_code_q    <= '0;
            bit_q         <= '0;
            cnt_q         <= '0;
            t_ref_q       <= '0;
            t_tst_q       <= '0;
            got_ref_q     <= 1'b0;
            got_tst_q     <= 1'b0;
            timeout_q     <= 1'b0;
            relax_q       <= '0;
            res_valid_q   <= 1'b0;
            res_ch_q      <= '0;
            res_code_q    <= '0;
            res_tref_q    <= '0;
            res_timeout_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ch_en_q       <= ch_en_d;
            meas_q        <= meas_d;
            ch_sel_q      <= ch_sel_d;
            cap_code_q    <= cap_code_d;
            bit_q         <= bit_d;
            cnt_q         <= cnt_d;
            t_ref_q       <= t_ref_d;
            t_tst_q       <= t_tst_d;
            got_ref_q     <= got_ref_d;
            got_tst_q     <= got_tst_d;
            timeout_q     <= timeout_d;
            relax_q       <= relax_d;
            res_valid_q   <= res_valid_d;
            res_ch_q      <= res_ch_d;
            res_code_q    <= res_code_d;
            res_tref_q    <= res_tref_d;
            res_timeout_q <= res_timeout_d;
            done_q        <= done_d;
        end
    end

    assign stim        = (state_q == StStim) || (state_q == StWaitIn) || (state_q == StMeasure);
    assign busy        = (state_q != StIdle);
    assign ch_sel      = ch_sel_q;
    assign cap_code    = cap_code_q;
    assign res_valid   = res_valid_q;
    assign res_ch      = res_ch_q;
    assign res_code    = res_code_q;
    assign res_tref    = res_tref_q;
    assign res_timeout = res_timeout_q;
    assign done        = done_q;

endmodule

// File: tb/tb_input_capa_sar_ctrl.sv
// Directed bench: a behavioural capacitance/delay model answers each stimulus edge,
// sweep scenarios are table driven, reset/busy/empty-mask cases are hand sequenced.
module tb_input_capa_sar_ctrl;

    localparam int N_CH = 4, CODE_W = 4, CNT_W = 8, RELAX_CYC = 8;

    logic              clk = 1'b0;
    logic              rst_n, start, evt_in, evt_ref, evt_tst;
    logic [N_CH-1:0]   ch_en;
    logic [1:0]        ch_sel, res_ch;
    logic              stim, busy, res_valid, res_timeout, done;
    logic [CODE_W-1:0] cap_code, res_code;
    logic [CNT_W-1:0]  res_tref;

    input_capa_sar_ctrl #(
        .N_CH(N_CH), .CODE_W(CODE_W), .CNT_W(CNT_W), .RELAX_CYC(RELAX_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ch_en(ch_en),
        .evt_in(evt_in), .evt_ref(evt_ref), .evt_tst(evt_tst),
        .ch_sel(ch_sel), .stim(stim), .cap_code(cap_code), .busy(busy),
        .res_valid(res_valid), .res_ch(res_ch), .res_code(res_code),
        .res_tref(res_tref), .res_timeout(res_timeout), .done(done)
    );

    always #5 clk = ~clk;

    // Modes: 0 normal, 1 test path never fires, 2 same-cycle events, 3 spurious pulses
    typedef struct {
        logic [3:0] m;
        int mode; int n_res; int ch0; int ch1; int code; int tref; int to; int trials;
    } vec_t;
    typedef struct { int ch; int code; int tref; int to; } res_t;

    vec_t vecs[5];
    res_t res_q[$];
    int   codes[$];
    int   mode, meas_len, done_cnt, bad_sel;
    logic [3:0] ch_en_cur;
    int   pass_cnt = 0, tot_cnt = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // Delay model: t_ref = 40, t_tst = 10 + 5*code counted from the counter restart
    initial begin : responder
        int c, tr, tt, k;
        evt_in = 0; evt_ref = 0; evt_tst = 0; meas_len = 0;
        forever begin
            @(negedge clk);
            if (stim && rst_n) begin
                c  = int'(cap_code);
                codes.push_back(c);
                tr = 40;
                tt = (mode == 2) ? 40 : 10 + 5 * c;
                @(negedge clk);
                if (mode == 3) begin evt_ref = 1; evt_tst = 1; end
                @(negedge clk);
                evt_ref = 0; evt_tst = 0; evt_in = 1;
                k = 0;
                while (k < 400) begin
                    @(negedge clk);
                    evt_in = 0;
                    if (!stim) break;
                    evt_ref = (k == tr) || (mode == 3 && k == tr + 2);
                    evt_tst = (mode != 1) && (k == tt);
                    k++;
                end
                evt_ref = 0; evt_tst = 0; evt_in = 0;
                meas_len = k;
            end
        end
    end

    // Output monitor, counters only ever grow
    initial begin : monitor
        done_cnt = 0; bad_sel = 0;
        forever begin
            @(negedge clk);
            if (res_valid)
                res_q.push_back('{int'(res_ch), int'(res_code), int'(res_tref), int'(res_timeout)});
            if (done) done_cnt++;
            if (stim && !ch_en_cur[ch_sel]) bad_sel++;
        end
    end

    task automatic pulse_start(input logic [3:0] m);
        @(negedge clk);
        ch_en = m; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int db);
        int n;
        n = 0;
        while (done_cnt == db && n < 6000) begin
            @(negedge clk); #1;
            n++;
        end
    endtask

    initial begin : main
        int rb, cb, db, bb, d1, d2, d3;
        int exp_codes[4];
        exp_codes = '{8, 4, 6, 7};
        rst_n = 0; start = 0; ch_en = '0; mode = 0; ch_en_cur = '0;
        vecs[0] = '{4'b0001, 0, 1, 0, 0, 6,  40, 0, 4};
        vecs[1] = '{4'b1010, 0, 2, 1, 3, 6,  40, 0, 8};
        vecs[2] = '{4'b0100, 1, 1, 2, 0, 8,  40, 1, 1};
        vecs[3] = '{4'b0001, 2, 1, 0, 0, 15, 40, 0, 4};
        vecs[4] = '{4'b1000, 3, 1, 3, 0, 6,  40, 0, 4};

        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_stim", int'(stim), 0);
        chk("rst_cap_code", int'(cap_code), 0);
        chk("rst_done_valid", int'({done, res_valid}), 0);
        @(negedge clk); rst_n = 1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            rb = res_q.size(); cb = codes.size(); db = done_cnt; bb = bad_sel;
            mode = vecs[v].mode; ch_en_cur = vecs[v].m;
            pulse_start(vecs[v].m);
            wait_done(db);
            repeat (3) @(negedge clk);
            #1;
            chk($sformatf("v%0d_done", v), done_cnt - db, 1);
            chk($sformatf("v%0d_nres", v), res_q.size() - rb, vecs[v].n_res);
            chk($sformatf("v%0d_trials", v), codes.size() - cb, vecs[v].trials);
            chk($sformatf("v%0d_badsel", v), bad_sel - bb, 0);
            if (res_q.size() > rb) begin
                chk($sformatf("v%0d_ch", v), res_q[rb].ch, vecs[v].ch0);
                chk($sformatf("v%0d_code", v), res_q[rb].code, vecs[v].code);
                chk($sformatf("v%0d_tref", v), res_q[rb].tref, vecs[v].tref);
                chk($sformatf("v%0d_timeout", v), res_q[rb].to, vecs[v].to);
            end
            if (vecs[v].n_res > 1 && res_q.size() > rb + 1) begin
                chk($sformatf("v%0d_ch_2nd", v), res_q[rb+1].ch, vecs[v].ch1);
                chk($sformatf("v%0d_code_2nd", v), res_q[rb+1].code, vecs[v].code);
            end
            if (vecs[v].mode == 1) chk("timeout_len", meas_len, 256);
            if (v == 0 && codes.size() >= cb + 4)
                for (int i = 0; i < 4; i++)
                    chk($sformatf("code_try%0d", i), codes[cb+i], exp_codes[i]);
            repeat (5) @(negedge clk);
        end

        // Empty mask: done on the third cycle after the start cycle
        rb = res_q.size(); ch_en_cur = 4'b0000;
        @(negedge clk); ch_en = 4'b0000; start = 1;
        @(negedge clk); start = 0; d1 = int'(done);
        @(negedge clk); d2 = int'(done);
        @(negedge clk); d3 = int'(done);
        chk("empty_done_seq", d1 * 4 + d2 * 2 + d3, 1);
        repeat (3) @(negedge clk);
        chk("empty_no_res", res_q.size() - rb, 0);

        // Start while busy is ignored
        rb = res_q.size(); db = done_cnt; mode = 0; ch_en_cur = 4'b0001;
        pulse_start(4'b0001);
        repeat (30) @(negedge clk);
        ch_en = 4'b1111; start = 1;
        @(negedge clk); start = 0;
        wait_done(db);
        repeat (100) @(negedge clk);
        #1;
        chk("busy_start_nres", res_q.size() - rb, 1);
        chk("busy_start_done", done_cnt - db, 1);
        if (res_q.size() > rb) chk("busy_start_code", res_q[rb].code, 6);

        // Reset during the second trial's measurement
        rb = res_q.size(); db = done_cnt; cb = codes.size();
        pulse_start(4'b0001);
        d1 = 0;
        while (!(codes.size() >= cb + 2 && stim) && d1 < 2000) begin
            @(negedge clk); d1++;
        end
        repeat (10) @(negedge clk);
        chk("pre_rst_stim", int'(stim), 1);
        rst_n = 0;
        #1;
        chk("mid_rst_stim_busy", int'({stim, busy}), 0);
        chk("mid_rst_code_sel", int'({cap_code, ch_sel}), 0);
        chk("mid_rst_res", int'({res_valid, res_timeout, done, res_ch, res_code}), 0);
        chk("mid_rst_tref", int'(res_tref), 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (600) @(negedge clk);
        #1;
        chk("post_rst_no_res", res_q.size() - rb, 0);
        chk("post_rst_no_done", done_cnt - db, 0);
        chk("post_rst_idle", int'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/input_capa_sar_ctrl.md
INPUT_CAPA_SAR_CTRL -- requirements
Module: input_capa_sar_ctrl

Interface
REQ-001 Parameter N_CH, default 4: number of measured input channels, legal range 1..16.
REQ-002 Parameter CODE_W, default 6: width of the test-capacitance code, legal range 2..10.
REQ-003 Parameter CNT_W, default 16: width of the propagation-time counter, in clock cycles.
REQ-004 Parameter RELAX_CYC, default 8: number of stimulus-low cycles between trials, for discharge.
REQ-005 Ports, in this order:
- clk  in  1  the single clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle measurement request.
- ch_en  in  N_CH  channel enable mask, sampled on the start cycle.
- evt_in  in  1  input-threshold crossing pulse; synchronous, one cycle wide.
- evt_ref  in  1  output-threshold crossing pulse of the circuit-under-load path.
- evt_tst  in  1  output-threshold crossing pulse of the test-capacitance path.
- ch_sel  out  clog2(N_CH) (min 1)  channel currently stimulated.
- stim  out  1  stimulus edge driven to both paths.
- cap_code  out  CODE_W  test-capacitance code.
- busy  out  1  high whenever the state is not IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_ch  out  clog2(N_CH)  channel of the result.
- res_code  out  CODE_W  final code.
- res_tref  out  CNT_W  last circuit propagation time.
- res_timeout  out  1  result was aborted by timeout.
- done  out  1  one-cycle pulse when the whole sweep ends.

Function
REQ-006 The FSM SHALL have states IDLE, SELECT, STIM, WAIT_IN, MEASURE, DECIDE, RELAX, REPORT, DONE.
REQ-007 In IDLE, start SHALL latch ch_en and go to SELECT; start while busy SHALL be ignored.
REQ-008 SELECT SHALL pick the lowest enabled, not yet measured channel, load cap_code with only its MSB set, and go to STIM; with no channel left it SHALL go to DONE.
REQ-009 STIM SHALL drive stim=1 for one cycle, then go to WAIT_IN; stim SHALL stay 1 through WAIT_IN and MEASURE and be 0 in every other state.
REQ-010 In WAIT_IN, evt_in SHALL clear the counter to 0 and go to MEASURE; evt_ref and evt_tst SHALL be ignored before evt_in.
REQ-011 In MEASURE the counter SHALL increment once per cycle.
- The first evt_ref SHALL latch t_ref = counter; the first evt_tst SHALL latch t_tst = counter.
- Later pulses of either event SHALL be ignored.
- Both events in the same cycle SHALL latch the same value.
- Once both are latched, the FSM SHALL go to DECIDE.
REQ-012 When the counter reaches all-ones in WAIT_IN or MEASURE without both events, the FSM SHALL go to REPORT with res_timeout=1 and res_code equal to the current cap_code.
REQ-013 DECIDE on the current bit b:
- t_tst > t_ref (unsigned) SHALL clear bit b; otherwise bit b stays set (equality keeps it).
- If b > 0, bit b-1 SHALL be set and the FSM SHALL go to RELAX.
- If b = 0, the FSM SHALL go to REPORT.
REQ-014 RELAX SHALL last exactly RELAX_CYC cycles, then go to STIM.
REQ-015 REPORT SHALL pulse res_valid for one cycle with res_ch, res_code, res_tref (last t_ref) and res_timeout, mark the channel measured, then go to RELAX-free SELECT.
- res_* SHALL hold their values until the next REPORT.
REQ-016 DONE SHALL pulse done for one cycle and return to IDLE.
- A start with ch_en all zero SHALL produce done on the third cycle after start, with no res_valid.
REQ-017 Each channel SHALL use exactly CODE_W trials, unless it times out.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE and set all of the following to 0: stim, busy, res_valid, res_timeout, done, cap_code, ch_sel, res_ch, res_code, res_tref and the counter. This applies mid-sweep as well.
REQ-019 After rst_n is released, the block SHALL need a new start; no partial result SHALL be reported.

Verification (CODE_W=4, N_CH=4, CNT_W=8, RELAX_CYC=8)
REQ-020 Single channel: ch_en=0001, evt_ref 40 cycles after evt_in, evt_tst (10+5*cap_code) cycles after evt_in.
- Required: codes tried 8, 4, 6, 7.
- Required: res_code=6, res_tref=40, res_timeout=0, then done.
REQ-021 Multi channel: ch_en=1010, each channel modeled as in REQ-020.
- Required: results for channel 1, then channel 3.
- Required: ch_sel never equals 0 or 2.
REQ-022 Timeout: evt_tst is never sent.
- Required: after 255 counting cycles, res_valid with res_timeout=1 and res_code=8.
REQ-023 Same-cycle events and edge cases:
- evt_ref and evt_tst in the same cycle SHALL keep the bit.
- Spurious evt_ref pulses in WAIT_IN and duplicate pulses in MEASURE SHALL not change t_ref.
REQ-024 Reset: rst_n is pulled low during MEASURE of the second trial.
- Required: all outputs 0 while reset is low, and no res_valid or done after release until a new start.
REQ-025 Start while busy and empty mask:
- A start while busy SHALL have no effect.
- ch_en=0000 SHALL give done 3 cycles after start.
